// File: rtl/river_cfg_pkg.sv
// River core-wide configuration constants shared by the L1/L2 interconnect blocks.
package river_cfg_pkg;

  localparam int CFG_CPU_ADDR_BITS    = 48;
  localparam int CFG_SYSBUS_DATA_BITS = 64;

endpackage

// File: rtl/river_l1arb_pkg.sv
// Types and constants for the River L1 arbiter: FSM states, control register struct and its reset value.
package river_l1arb_pkg;

  typedef enum logic [1:0] {
    L1ARB_IDLE,
    L1ARB_REQUEST,
    L1ARB_RESPONSE
  } l1arb_state_type;

  localparam logic [9:0] L1ARB_TIMEOUT_MAX = 10'd1023;

  // Slot indices are 3 bits wide, enough for the largest supported nslots of 8.
  typedef struct packed {
    l1arb_state_type state;
    logic [2:0]      rr_ptr;
    logic [2:0]      owner;
    logic [9:0]      tmo_cnt;
  } l1arb_ctrl_type;

  localparam l1arb_ctrl_type L1ARB_CTRL_RESET = '{
    state:   L1ARB_IDLE,
    rr_ptr:  3'd0,
    owner:   3'd0,
    tmo_cnt: 10'd0
  };

  function automatic logic [2:0] l1arb_next_slot(input logic [2:0] slot, input int nslots);
    return (int'(slot) == nslots - 1) ? 3'd0 : slot + 3'd1;
  endfunction

endpackage

// File: rtl/river_rr_select.sv
// Round-robin selector: first asserted request at or after rr_ptr, wrapping modulo nslots.
module river_rr_select #(
  parameter int nslots = 4
) (
  input  logic [nslots-1:0] req,
  input  logic [2:0]        rr_ptr,
  output logic [2:0]        winner,
  output logic              any
);

  logic [2*nslots-1:0] req_dbl;
  logic [nslots-1:0]   rot;

  // Rotating right by rr_ptr puts slot rr_ptr at bit 0, so a plain priority encode is fair.
  assign req_dbl = {req, req} >> rr_ptr;
  assign rot     = req_dbl[nslots-1:0];

  always_comb begin
    winner = 3'd0;
    any    = 1'b0;
    for (int i = nslots - 1; i >= 0; i--) begin
      if (rot[i]) begin
        winner = 3'((int'(rr_ptr) + i) % nslots);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/river_l1_arbiter.sv
// Round-robin arbiter sharing the River L2/memory port among L1 requesters, one transaction outstanding.
// Optional response timeout enabled by defining RIVER_L1ARB_TIMEOUT_EN.
module river_l1_arbiter
  import river_l1arb_pkg::*;
  import river_cfg_pkg::*;
#(
  parameter int nslots = 4,
  parameter int abits  = CFG_CPU_ADDR_BITS,
  parameter int dbits  = CFG_SYSBUS_DATA_BITS
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic [nslots-1:0]         i_req_valid,
  output logic [nslots-1:0]         o_req_ready,
  input  logic [nslots-1:0]         i_req_write,
  input  logic [nslots*abits-1:0]   i_req_addr,
  input  logic [nslots*dbits-1:0]   i_req_wdata,
  input  logic [nslots*dbits/8-1:0] i_req_wstrb,
  output logic [nslots-1:0]         o_resp_valid,
  output logic [dbits-1:0]          o_resp_data,
  output logic                      o_resp_err,
  output logic                      o_mem_req_valid,
  input  logic                      i_mem_req_ready,
  output logic                      o_mem_req_write,
  output logic [abits-1:0]          o_mem_req_addr,
  output logic [dbits-1:0]          o_mem_req_wdata,
  output logic [dbits/8-1:0]        o_mem_req_wstrb,
  input  logic                      i_mem_resp_valid,
  input  logic [dbits-1:0]          i_mem_resp_data,
  input  logic                      i_mem_resp_err,
  output logic                      o_busy
);

  localparam int SW = dbits / 8;
  localparam logic [nslots-1:0] SLOT_ONE = 1;

  l1arb_ctrl_type      ctrl_reg, ctrl_next;
  logic                write_reg;
  logic [abits-1:0]    addr_reg;
  logic [dbits-1:0]    wdata_reg;
  logic [SW-1:0]       wstrb_reg;

  logic [2:0]          winner;
  logic                any;
  logic                grant;
  logic                resp_fire;
  logic                sel_write;
  logic [abits-1:0]    sel_addr;
  logic [dbits-1:0]    sel_wdata;
  logic [SW-1:0]       sel_wstrb;

  river_rr_select #(.nslots(nslots)) u_select (
    .req    (i_req_valid),
    .rr_ptr (ctrl_reg.rr_ptr),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < nslots; i++) begin
      if (winner == 3'(i)) begin
        sel_write = i_req_write[i];
        sel_addr  = i_req_addr[i*abits +: abits];
        sel_wdata = i_req_wdata[i*dbits +: dbits];
        sel_wstrb = i_req_wstrb[i*SW +: SW];
      end
    end
  end

  always_comb begin
    ctrl_next       = ctrl_reg;
    grant           = 1'b0;
    resp_fire       = 1'b0;
    o_mem_req_valid = 1'b0;
    o_resp_data     = '0;
    o_resp_err      = 1'b0;
    case (ctrl_reg.state)
      L1ARB_IDLE: begin
        // Gated by i_nrst so no grant is offered while reset is held.
        if (any && i_nrst) begin
          grant           = 1'b1;
          ctrl_next.owner = winner;
          ctrl_next.state = L1ARB_REQUEST;
        end
      end
      L1ARB_REQUEST: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          ctrl_next.state   = L1ARB_RESPONSE;
          ctrl_next.tmo_cnt = 10'd0;
        end
      end
      L1ARB_RESPONSE: begin
`ifdef RIVER_L1ARB_TIMEOUT_EN
        if (ctrl_reg.tmo_cnt == L1ARB_TIMEOUT_MAX) begin
          resp_fire        = 1'b1;
          o_resp_err       = 1'b1;
          ctrl_next.state  = L1ARB_IDLE;
          ctrl_next.rr_ptr = l1arb_next_slot(ctrl_reg.owner, nslots);
        end else begin
          resp_fire         = i_mem_resp_valid;
          o_resp_data       = i_mem_resp_data;
          o_resp_err        = i_mem_resp_err;
          ctrl_next.tmo_cnt = ctrl_reg.tmo_cnt + 10'd1;
          if (i_mem_resp_valid) begin
            ctrl_next.state  = L1ARB_IDLE;
            ctrl_next.rr_ptr = l1arb_next_slot(ctrl_reg.owner, nslots);
          end
        end
`else
        resp_fire   = i_mem_resp_valid;
        o_resp_data = i_mem_resp_data;
        o_resp_err  = i_mem_resp_err;
        if (i_mem_resp_valid) begin
          ctrl_next.state  = L1ARB_IDLE;
          ctrl_next.rr_ptr = l1arb_next_slot(ctrl_reg.owner, nslots);
        end
`endif
      end
      default: ctrl_next.state = L1ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ctrl_reg  <= L1ARB_CTRL_RESET;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else begin
      ctrl_reg <= ctrl_next;
      if (grant) begin
        write_reg <= sel_write;
        addr_reg  <= sel_addr;
        wdata_reg <= sel_wdata;
        wstrb_reg <= sel_wstrb;
      end
    end
  end

  assign o_req_ready     = grant ? (SLOT_ONE << winner) : '0;
  assign o_resp_valid    = resp_fire ? (SLOT_ONE << ctrl_reg.owner) : '0;
  assign o_mem_req_write = write_reg;
  assign o_mem_req_addr  = addr_reg;
  assign o_mem_req_wdata = wdata_reg;
  assign o_mem_req_wstrb = wstrb_reg;
  assign o_busy          = (ctrl_reg.state != L1ARB_IDLE);

endmodule

// File: tb/tb_river_l1_arbiter.sv
// Directed bench for river_l1_arbiter: expected responses are queued at grant time and popped when o_resp_valid fires.
module tb_river_l1_arbiter;

  localparam int NS = 4;
  localparam int AB = 48;
  localparam int DB = 64;
  localparam int SB = DB / 8;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [NS-1:0]   req_valid = '0;
  logic [NS-1:0]   req_ready;
  logic [NS-1:0]   req_write = '0;
  logic [NS*AB-1:0] req_addr = '0;
  logic [NS*DB-1:0] req_wdata = '0;
  logic [NS*SB-1:0] req_wstrb = '0;
  logic [NS-1:0]   resp_valid;
  logic [DB-1:0]   resp_data;
  logic            resp_err;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic            mem_req_write;
  logic [AB-1:0]   mem_req_addr;
  logic [DB-1:0]   mem_req_wdata;
  logic [SB-1:0]   mem_req_wstrb;
  logic            mem_resp_valid = 1'b0;
  logic [DB-1:0]   mem_resp_data = '0;
  logic            mem_resp_err = 1'b0;
  logic            busy;

  always #5 clk = ~clk;

  river_l1_arbiter #(.nslots(NS), .abits(AB), .dbits(DB)) dut (
    .i_clk            (clk),
    .i_nrst           (nrst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .i_req_wstrb      (req_wstrb),
    .o_resp_valid     (resp_valid),
    .o_resp_data      (resp_data),
    .o_resp_err       (resp_err),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_req_write  (mem_req_write),
    .o_mem_req_addr   (mem_req_addr),
    .o_mem_req_wdata  (mem_req_wdata),
    .o_mem_req_wstrb  (mem_req_wstrb),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .i_mem_resp_err   (mem_resp_err),
    .o_busy           (busy)
  );

  typedef struct {
    int          slot;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AB-1:0] addr_of(input int s);
    return 48'h2000 + 48'(s * 256);
  endfunction

  task automatic set_req(input int s, input logic v, input logic w, input logic [AB-1:0] a,
                         input logic [DB-1:0] d);
    req_valid[s] = v;
    req_write[s] = w;
    req_addr[s*AB +: AB]  = a;
    req_wdata[s*DB +: DB] = d;
    req_wstrb[s*SB +: SB] = 8'hFF;
  endtask

  task automatic push_grant(input int s, input logic [63:0] d, input logic e);
    logic [NS-1:0] ev;
    exp_t x;
    ev = 4'b0001 << s;
    chk($sformatf("grant_slot%0d", s), 64'(req_ready), 64'(ev));
    x.slot = s;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic check_resp();
    exp_t x;
    logic [NS-1:0] ev;
    chk("sb_pending", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      x  = sb.pop_front();
      ev = 4'b0001 << x.slot;
      chk($sformatf("resp_valid_slot%0d", x.slot), 64'(resp_valid), 64'(ev));
      chk($sformatf("resp_data_slot%0d", x.slot), resp_data, x.data);
      chk($sformatf("resp_err_slot%0d", x.slot), 64'(resp_err), 64'(x.err));
    end
  endtask

  // Full transaction with ready and response each given without wait states.
  task automatic run_txn(input int s, input logic w, input logic [AB-1:0] a,
                         input logic [63:0] rd, input logic re);
    #1;
    push_grant(s, rd, re);
    tick();
    chk("mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("mem_req_addr", 64'(mem_req_addr), 64'(a));
    chk("mem_req_write", 64'(mem_req_write), 64'(w));
    chk("no_grant_in_req", 64'(req_ready), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = rd;
    mem_resp_err   = re;
    #1;
    check_resp();
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    sb.delete();
    tick();
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    int last_grant;
    int n;
    int seen;
    int order[5] = '{0, 1, 2, 3, 0};

    // Reset state
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_mem_req_wstrb", 64'(mem_req_wstrb), 64'd0);
    do_reset();

    // Single write request on slot 2
    set_req(2, 1'b1, 1'b1, 48'h1000, 64'h1122_3344_5566_7788);
    #1;
    push_grant(2, 64'hAB, 1'b0);
    tick();
    req_valid[2] = 1'b0;
    #1;
    chk("t1_mem_req_valid", 64'(mem_req_valid), 64'd1);
    chk("t1_mem_req_addr", 64'(mem_req_addr), 64'h1000);
    chk("t1_mem_req_write", 64'(mem_req_write), 64'd1);
    chk("t1_mem_req_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
    chk("t1_mem_req_wstrb", 64'(mem_req_wstrb), 64'hFF);
    chk("t1_busy", 64'(busy), 64'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("t1_resp_idle_before", 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hAB;
    #1;
    check_resp();
    tick();
    mem_resp_valid = 1'b0;
    chk("t1_back_idle", 64'(busy), 64'd0);

    // Round robin under full contention after reset: 0,1,2,3,0, one grant per 3 cycles
    do_reset();
    for (int s = 0; s < NS; s++) set_req(s, 1'b1, 1'b0, addr_of(s), 64'(s));
    last_grant = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) chk("rr_spacing", 64'(cyc - last_grant), 64'd3);
      last_grant = cyc;
      run_txn(order[k], 1'b0, addr_of(order[k]), 64'h100 + 64'(k), 1'b0);
    end

    // Memory stalls request acceptance for 5 cycles; slot 1 is next and ends with an error
    #1;
    push_grant(1, 64'hEE, 1'b1);
    tick();
    set_req(1, 1'b1, 1'b0, 48'hDEAD, 64'd0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_mem_req_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr_stable", 64'(mem_req_addr), 64'(addr_of(1)));
      chk("stall_no_grant", 64'(req_ready), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hEE;
    mem_resp_err   = 1'b1;
    #1;
    check_resp();
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;

    // A memory response during Request is ignored
    for (int s = 0; s < NS; s++) req_valid[s] = 1'b0;
    set_req(2, 1'b1, 1'b1, 48'h3000, 64'h5A5A);
    #1;
    push_grant(2, 64'h55, 1'b0);
    tick();
    req_valid[2]   = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h99;
    #1;
    chk("req_state_resp_ignored", 64'(resp_valid), 64'd0);
    tick();
    chk("still_in_request", 64'(mem_req_valid), 64'd1);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h55;
    #1;
    check_resp();
    tick();
    mem_resp_valid = 1'b0;

    // Slot 3 with a silent memory
    set_req(3, 1'b1, 1'b0, 48'h4000, 64'd0);
    #1;
`ifdef RIVER_L1ARB_TIMEOUT_EN
    push_grant(3, 64'd0, 1'b1);
`else
    push_grant(3, 64'h77, 1'b0);
`endif
    tick();
    req_valid[3]  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_data = 64'hFFFF;
`ifdef RIVER_L1ARB_TIMEOUT_EN
    n = 0;
    while (resp_valid == '0 && n < 1100) begin
      tick();
      n = n + 1;
    end
    chk("tmo_cycles", 64'(n), 64'd1023);
    check_resp();
    tick();
    mem_resp_valid = 1'b1;
    #1;
    chk("late_resp_dropped", 64'(resp_valid), 64'd0);
    chk("tmo_back_idle", 64'(busy), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
`else
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (resp_valid != '0) seen = seen + 1;
      tick();
    end
    chk("wait_no_spurious_resp", 64'(seen), 64'd0);
    chk("wait_still_busy", 64'(busy), 64'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h77;
    #1;
    check_resp();
    tick();
    mem_resp_valid = 1'b0;
`endif

    // Reset asserted mid-Response aborts the transaction
    set_req(1, 1'b1, 1'b1, 48'h5000, 64'hCAFE);
    #1;
    push_grant(1, 64'd0, 1'b0);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    nrst = 1'b0;
    sb.delete();
    mem_resp_valid = 1'b1;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'(mem_req_addr), 64'd0);
    chk("mid_rst_write", 64'(mem_req_write), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    req_valid[1] = 1'b0;
    nrst = 1'b1;
    set_req(0, 1'b1, 1'b0, addr_of(0), 64'd0);
    set_req(3, 1'b1, 1'b0, addr_of(3), 64'd0);
    run_txn(0, 1'b0, addr_of(0), 64'h31, 1'b0);
    for (int s = 0; s < NS; s++) req_valid[s] = 1'b0;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
